ret_addr_stack: RTL and testbench

Return-address stack (RAS) for the fetch-stage branch predictor. It consumes the call/return classification produced by branch decode. Calls push the return address. Returns pop, and the predicted target is exposed on `top_addr`. The block is a circular buffer with overwrite-on-overflow, a registered pointer/occupancy, and pipeline flush handling.

---
 rtl/ret_addr_stack_if.sv | 38 +++
 rtl/ret_addr_stack.sv | 67 ++++++
 tb/tb_ret_addr_stack.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ret_addr_stack_if.sv
// rtl/ret_addr_stack_if.sv - call/return request and prediction bundle for the return-address stack (RAS_RECOVER_EN adds snapshot ports)
interface ret_addr_stack_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              push_valid;
    logic [31:0]       push_addr;
    logic              pop_valid;
    logic              flush;
    logic [31:0]       top_addr;
    logic              top_valid;
`ifdef RAS_RECOVER_EN
    logic [PTR_W-1:0]  snap_ptr;
    logic [PTR_W:0]    snap_cnt;
    logic              recover_valid;
    logic [PTR_W-1:0]  recover_ptr;
    logic [PTR_W:0]    recover_cnt;
`endif

    modport master (
        output push_valid, push_addr, pop_valid, flush,
`ifdef RAS_RECOVER_EN
        output recover_valid, recover_ptr, recover_cnt,
        input  snap_ptr, snap_cnt,
`endif
        input  top_addr, top_valid
    );

    modport slave (
        input  push_valid, push_addr, pop_valid, flush,
`ifdef RAS_RECOVER_EN
        input  recover_valid, recover_ptr, recover_cnt,
        output snap_ptr, snap_cnt,
`endif
        output top_addr, top_valid
    );
endinterface

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - circular return-address stack with overwrite-on-overflow; RAS_RECOVER_EN enables snapshot/restore
module ret_addr_stack #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    ret_addr_stack_if.slave   ras
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] ptr, ptr_nxt, wr_idx;
    logic [PTR_W:0]   cnt, cnt_nxt;
    logic             wr_en;
    logic             empty;

    assign empty         = (cnt == '0);
    assign ras.top_valid = !empty;
    assign ras.top_addr  = empty ? 32'h0 : mem[ptr];
`ifdef RAS_RECOVER_EN
    assign ras.snap_ptr  = ptr;
    assign ras.snap_cnt  = cnt;
`endif

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        if (ras.flush) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
`ifdef RAS_RECOVER_EN
        end else if (ras.recover_valid) begin
            ptr_nxt = ras.recover_ptr;
            cnt_nxt = ras.recover_cnt;
`endif
        end else if (ras.push_valid && ras.pop_valid) begin
            // call-and-return in one instruction replaces the top in place
            wr_en = 1'b1;
            if (empty) cnt_nxt = 1;
        end else if (ras.push_valid) begin
            ptr_nxt = ptr + 1'b1;
            wr_idx  = ptr + 1'b1;
            wr_en   = 1'b1;
            if (cnt != FULL) cnt_nxt = cnt + 1'b1;
        end else if (ras.pop_valid && !empty) begin
            ptr_nxt = ptr - 1'b1;
            cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            ptr <= ptr_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_idx] <= ras.push_addr;
    end
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb/tb_ret_addr_stack.sv - randomized bench for ret_addr_stack against a queue model of the return stack
module tb_ret_addr_stack;
    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ret_addr_stack_if #(.DEPTH(DEPTH)) bus ();
    ret_addr_stack #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .ras(bus));

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [31:0] q[$];

    // Model: newest return address at the back; overflow discards the oldest.
    always @(posedge clk) begin
        if (rst || bus.flush) begin
            q.delete();
`ifdef RAS_RECOVER_EN
        end else if (bus.recover_valid) begin
            q.delete();
`endif
        end else if (bus.push_valid && bus.pop_valid) begin
            if (q.size() == 0) q.push_back(bus.push_addr);
            else q[q.size()-1] = bus.push_addr;
        end else if (bus.push_valid) begin
            q.push_back(bus.push_addr);
            if (q.size() > DEPTH) void'(q.pop_front());
        end else if (bus.pop_valid && q.size() != 0) begin
            void'(q.pop_back());
        end
    end

    always @(negedge clk) begin
        logic        exp_v;
        logic [31:0] exp_a;
        if (chk_en) begin
            exp_v = (q.size() != 0);
            exp_a = exp_v ? q[q.size()-1] : 32'h0;
            n_chk++;
            if (bus.top_valid !== exp_v || bus.top_addr !== exp_a) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t top_valid=%0b top_addr=%h required %0b %h",
                         $time, bus.top_valid, bus.top_addr, exp_v, exp_a);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit p, input logic [31:0] a, input bit o, input bit f);
        bus.push_valid = p;
        bus.push_addr  = a;
        bus.pop_valid  = o;
        bus.flush      = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.push_valid = 0; bus.push_addr = 0; bus.pop_valid = 0; bus.flush = 0;
`ifdef RAS_RECOVER_EN
        bus.recover_valid = 0; bus.recover_ptr = '0; bus.recover_cnt = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_top_valid", 32'(bus.top_valid), 32'h0);
        chk("reset_top_addr", bus.top_addr, 32'h0);
`ifdef RAS_RECOVER_EN
        chk("reset_snap_ptr", 32'(bus.snap_ptr), 32'h0);
        chk("reset_snap_cnt", 32'(bus.snap_cnt), 32'h0);
`endif
        rst = 1'b0;
        chk_en = 1'b1;

        cyc(1, 32'h8000_0010, 0, 0);
        chk("push1_valid", 32'(bus.top_valid), 32'h1);
        chk("push1_addr", bus.top_addr, 32'h8000_0010);
        cyc(0, 0, 1, 0);
        chk("pop1_valid", 32'(bus.top_valid), 32'h0);
        chk("pop1_addr", bus.top_addr, 32'h0);

        for (int i = 0; i < 10; i++) cyc(1, 32'h100 + 32'(4*i), 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk("overflow_pop_seq", bus.top_addr, 32'h124 - 32'(4*k));
            cyc(0, 0, 1, 0);
        end
        chk("overflow_drained", 32'(bus.top_valid), 32'h0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("underflow_addr", bus.top_addr, 32'h0);

        repeat (3) cyc(0, 0, 1, 0);
        cyc(1, 32'h200, 0, 0);
        chk("after_underflow_push", bus.top_addr, 32'h200);
        cyc(0, 0, 1, 0);
        chk("no_phantom", 32'(bus.top_valid), 32'h0);

        cyc(1, 32'h300, 0, 0);
        cyc(1, 32'h304, 0, 0);
        cyc(1, 32'h400, 1, 0);
        chk("pushpop_replace", bus.top_addr, 32'h400);
        cyc(0, 0, 1, 0);
        chk("pushpop_then_pop", bus.top_addr, 32'h300);
        cyc(0, 0, 0, 1);

        cyc(1, 32'h500, 0, 0);
        cyc(1, 32'h504, 0, 0);
        cyc(1, 32'h508, 0, 1);
        chk("flush_wins", 32'(bus.top_valid), 32'h0);
        cyc(1, 32'h600, 0, 0);
        chk("push_after_flush", bus.top_addr, 32'h600);
        cyc(0, 0, 0, 1);

`ifdef RAS_RECOVER_EN
        begin
            logic [PTR_W-1:0] sp;
            logic [PTR_W:0]   sc;
            chk_en = 1'b0;
            cyc(1, 32'h700, 0, 0);
            sp = bus.snap_ptr;
            sc = bus.snap_cnt;
            chk("snap_ptr", 32'(sp), 32'h1);
            chk("snap_cnt", 32'(sc), 32'h1);
            cyc(1, 32'h704, 0, 0);
            cyc(1, 32'h708, 0, 0);
            cyc(0, 0, 1, 0);
            bus.recover_valid = 1; bus.recover_ptr = sp; bus.recover_cnt = sc;
            cyc(0, 0, 0, 0);
            chk("recover_addr", bus.top_addr, 32'h700);
            chk("recover_valid", 32'(bus.top_valid), 32'h1);
            cyc(0, 0, 0, 1);
            chk("recover_flush", 32'(bus.top_valid), 32'h0);
            bus.recover_valid = 0;
            cyc(0, 0, 0, 1);
            chk_en = 1'b1;
        end
`endif

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            rst = (r == 3);
            cyc(($urandom % 100) < 55, $urandom & 32'hFFFF_FFFC, ($urandom % 100) < 45, r < 3);
            rst = 1'b0;
        end
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
